// File: rtl/mul_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mul_sequencer
//   Multi-cycle shift-add multiplier that sits beside the single-cycle EX-stage
//   ALU. It accepts one MUL (ALUCtrl_i == MUL_CODE) while idle and stalls the
//   pipeline while it iterates. It then returns the low WIDTH bits of the
//   product together with a one-cycle valid pulse. Non-MUL ops are ignored.
//   The low bits are the same for signed and unsigned operands.
//
// Configuration macro:
//   MUL_SEQ_EARLY_EXIT_EN - when defined, iteration stops as soon as the
//                           remaining multiplier bits are all zero. Latency is
//                           then 2 + index of the highest set bit of data2_i.
//                           When undefined, latency is always WIDTH+1.
//
// Ports:
//   clk_i      in   1      clock, rising edge
//   rst_i      in   1      synchronous reset, active-high
//   valid_i    in   1      EX-stage op valid
//   ALUCtrl_i  in   3      ALU control code
//   data1_i    in   WIDTH  multiplicand (rs1)
//   data2_i    in   WIDTH  multiplier (rs2)
//   flush_i    in   1      abort in-flight multiply
//   stall_o    out  1      combinational: hold pipeline while a multiply is pending
//   busy_o     out  1      registered: sequencer not idle
//   valid_o    out  1      registered one-cycle pulse, result_o valid
//   result_o   out  WIDTH  registered (data1*data2) mod 2^WIDTH, held until next result
// -----------------------------------------------------------------------------
module mul_sequencer #(
    parameter int          WIDTH    = 32,
    parameter logic [2:0]  MUL_CODE = 3'b000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             valid_r;
    logic [WIDTH-1:0] result_r;

    logic             start_s;
    logic             last_s;
    logic [WIDTH-1:0] addend_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             stall_s;

    // Accept decision, one shift-add step, next-state and stall generation.
    always_comb begin
        start_s      = 1'b0;
        last_s       = 1'b0;
        addend_s     = {WIDTH{1'b0}};
        acc_next_s   = acc_r;
        stall_s      = 1'b0;
        state_next_s = state_r;

        start_s = valid_i & (ALUCtrl_i == MUL_CODE) & (state_r == ST_IDLE) & ~flush_i;

        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        // Carry out of the top bit is discarded: only the low WIDTH bits matter.
        acc_next_s = acc_r + addend_s;

`ifdef MUL_SEQ_EARLY_EXIT_EN
        // Stop once the bits still to be shifted in after this step are all zero.
        last_s = (cnt_r == CNT_LAST) || (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
        last_s = (cnt_r == CNT_LAST);
`endif

        stall_s = start_s | (state_r == ST_BUSY);

        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_next_s = ST_IDLE;
                end else if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, shift-add datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            // The pulse and the result are registered on entry to DONE, so both
            // are visible during the DONE cycle itself. A flush that arrives in
            // DONE therefore only returns the FSM to IDLE.
            valid_r <= (state_next_s == ST_DONE);

            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        mcand_r  <= data1_i;
                        mplier_r <= data2_i;
                        acc_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                ST_BUSY: begin
                    if (!flush_i) begin
                        acc_r    <= acc_next_s;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        if (last_s) begin
                            result_r <= acc_next_s;
                        end else begin
                            // Counter stops at WIDTH-1 and never wraps.
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign stall_o  = stall_s;
    assign busy_o   = busy_r;
    assign valid_o  = valid_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_mul_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for mul_sequencer (WIDTH = 32).
module tb_mul_sequencer;

    localparam int W = 32;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic [2:0]   alu;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic         flush;
    logic         stall_o;
    logic         busy_o;
    logic         valid_o;
    logic [W-1:0] result_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.WIDTH(W), .MUL_CODE(3'b000)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .ALUCtrl_i (alu),
        .data1_i   (d1),
        .data2_i   (d2),
        .flush_i   (flush),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .result_o  (result_o)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Number of iteration cycles between the accept edge and the result.
    function automatic int busy_cycles(input logic [W-1:0] b);
        int hi;
        hi = 0;
        if (!EARLY) return W;
        for (int i = 0; i < W; i++) if (b[i]) hi = i;
        return hi + 1;
    endfunction

    function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
    endfunction

    bit           m_known  = 1'b0;
    bit           m_active = 1'b0;   // iterating (stall held)
    bit           m_valid  = 1'b0;   // result-pulse cycle
    int           m_left   = 0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_prod   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1'b1; m_active = 1'b0; m_valid = 1'b0; m_left = 0; m_result = '0;
        end else if (m_known) begin
            if (m_valid) begin
                m_valid = 1'b0;
            end else if (m_active) begin
                if (flush) begin
                    m_active = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_active = 1'b0; m_valid = 1'b1; m_result = m_prod;
                    end
                end
            end else if (valid && alu == 3'b000 && !flush) begin
                m_active = 1'b1;
                m_left   = busy_cycles(d2);
                m_prod   = prod(d1, d2);
            end
        end
    end

    // Compare DUT against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        if (m_known) begin
            chk("busy_o", W'(busy_o), W'(m_active || m_valid));
            chk("valid_o", W'(valid_o), W'(m_valid));
            chk("result_o", result_o, m_result);
            chk("stall_o", W'(stall_o),
                W'(m_active || (!m_valid && valid && alu == 3'b000 && !flush)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [2:0] a, input logic [W-1:0] x, input logic [W-1:0] y);
        valid = v; alu = a; d1 = x; d2 = y;
    endtask

    // Entered at accept edge + 2; returns at the edge after the pulse + 2.
    task automatic wait_done(input string name, input int exp_edges, input logic [W-1:0] exp_res);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk); n++;
            @(negedge clk); seen = valid_o;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s: no valid_o pulse within 200 cycles", name);
        end else begin
            chk({name, " latency"}, W'(n), W'(exp_edges));
            chk({name, " result"}, result_o, exp_res);
        end
        tick(1);
    endtask

    task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_edges, input logic [W-1:0] exp_res);
        drive(1'b1, 3'b000, a, b);
        tick(1);
        valid = 1'b0;
        wait_done(name, exp_edges, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 3'b000, '0, '0);
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", W'(busy_o), '0);
        chk("reset result", result_o, '0);
        tick(1);

        // Basic multiply, full latency.
        run_mul("7*6", 32'd7, 32'd6, EARLY ? 3 : 32, 32'd42);

        // Flush after ten iteration cycles: no pulse, result keeps 42.
        drive(1'b1, 3'b000, 32'd9, 32'h8000_0009);
        tick(1);
        valid = 1'b0;
        tick(10);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush busy", W'(busy_o), '0);
        chk("flush result", result_o, 32'd42);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) pulses++;
        end
        chk("flush pulses", W'(pulses), '0);
        tick(1);

        // Zero multiplier still runs the full latency (early exit: two cycles).
        run_mul("x*0", 32'hDEAD_BEEF, 32'd0, EARLY ? 1 : 32, 32'd0);

        // Non-MUL op never stalls.
        drive(1'b1, 3'b100, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("add stall", W'(stall_o), '0);
            chk("add busy", W'(busy_o), '0);
            tick(1);
        end

        // Back-to-back: second request held through BUSY/DONE, accepted after DONE.
        drive(1'b1, 3'b000, 32'd3, 32'd5);
        tick(1);
        drive(1'b1, 3'b000, 32'd4, 32'd4);
        wait_done("3*5", EARLY ? 3 : 32, 32'd15);
        @(negedge clk);
        chk("b2b stall", W'(stall_o), 32'd1);
        chk("b2b busy", W'(busy_o), '0);
        tick(1);
        valid = 1'b0;
        wait_done("4*4", EARLY ? 3 : 32, 32'd16);

        // Overflow wrap.
        run_mul("ffff^2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0001);
        run_mul("8000*2", 32'h8000_0000, 32'd2, EARLY ? 2 : 32, 32'h0000_0000);
        run_mul("x*1", 32'h1234_5678, 32'd1, EARLY ? 1 : 32, 32'h1234_5678);

        // Reset for two cycles in the middle of an iteration.
        drive(1'b1, 3'b000, 32'd5, 32'h8000_0005);
        tick(1);
        valid = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst busy", W'(busy_o), '0);
        chk("rst stall", W'(stall_o), '0);
        chk("rst valid", W'(valid_o), '0);
        chk("rst result", result_o, '0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
